// File: rtl/ex_mem_pkg.sv
// Shared widths, control constants and bundle types
// for the EX/MEM pipeline register.
package ex_mem_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;
  localparam int RegAddrBus   = 5;
  localparam int CntBus       = 2;
  localparam int StallBus     = 6;

  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic Stop         = 1'b1;
  localparam logic NoStop       = 1'b0;

  localparam logic [RegBus-1:0]       ZeroWord   = '0;
  localparam logic [DoubleRegBus-1:0] ZeroDouble = '0;
  localparam logic [RegAddrBus-1:0]   NopRegAddr = '0;
  localparam logic [CntBus-1:0]       ZeroCnt    = '0;

  typedef struct packed {
    logic [RegAddrBus-1:0] wd;
    logic                  wreg;
    logic [RegBus-1:0]     wdata;
    logic [RegBus-1:0]     hi;
    logic [RegBus-1:0]     lo;
    logic                  whilo;
  } ex_mem_t;

  typedef enum logic [1:0] {
    PR_HOLD,
    PR_BUBBLE,
    PR_ADVANCE
  } pr_op_t;

  // A stalled stage feeding a running stage emits a bubble.
  function automatic pr_op_t pr_op(
    input logic cur,
    input logic nxt
  );
    if (cur == NoStop)
      return PR_ADVANCE;
    else if (nxt == NoStop)
      return PR_BUBBLE;
    else
      return PR_HOLD;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_stall.sv
// Generic stage register with the
// bubble / hold / advance stall rule.
module ex_mem_pipe_reg_stall
  import ex_mem_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         stall_cur,
  input  logic         stall_nxt,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  pr_op_t op;

  assign op = pr_op(stall_cur, stall_nxt);

  always_ff @(posedge Clk) begin
    if (Rst_n == RstEnable) begin
      q <= '0;
    end else begin
      unique case (op)
        PR_ADVANCE: q <= d;
        PR_BUBBLE:  q <= '0;
        PR_HOLD:    q <= q;
        default:    q <= q;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with the multi-cycle
// accumulate feedback (hilo_temp / cnt) path.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [StallBus-1:0]     stall,
  input  logic [RegAddrBus-1:0]   ex_wd,
  input  logic                    ex_wreg,
  input  logic [RegBus-1:0]       ex_wdata,
  input  logic [RegBus-1:0]       ex_hi,
  input  logic [RegBus-1:0]       ex_lo,
  input  logic                    ex_whilo,
  input  logic [DoubleRegBus-1:0] hilo_i,
  input  logic [CntBus-1:0]       cnt_i,
  output logic [RegAddrBus-1:0]   mem_wd,
  output logic                    mem_wreg,
  output logic [RegBus-1:0]       mem_wdata,
  output logic [RegBus-1:0]       mem_hi,
  output logic [RegBus-1:0]       mem_lo,
  output logic                    mem_whilo,
  output logic [DoubleRegBus-1:0] hilo_o,
  output logic [CntBus-1:0]       cnt_o
);

  ex_mem_t ex_bus;
  ex_mem_t mem_bus;
  pr_op_t  op;
  logic    unused_stall;

  assign unused_stall = ^{stall[5], stall[2:0]};

  assign ex_bus.wd    = ex_wd;
  assign ex_bus.wreg  = ex_wreg;
  assign ex_bus.wdata = ex_wdata;
  assign ex_bus.hi    = ex_hi;
  assign ex_bus.lo    = ex_lo;
  assign ex_bus.whilo = ex_whilo;

  ex_mem_pipe_reg_stall #(
    .W($bits(ex_mem_t))
  ) u_reg (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .stall_cur(stall[STALL_EX]),
    .stall_nxt(stall[STALL_MEM]),
    .d        (ex_bus),
    .q        (mem_bus)
  );

  assign mem_wd    = mem_bus.wd;
  assign mem_wreg  = mem_bus.wreg;
  assign mem_wdata = mem_bus.wdata;
  assign mem_hi    = mem_bus.hi;
  assign mem_lo    = mem_bus.lo;
  assign mem_whilo = mem_bus.whilo;

  assign op = pr_op(stall[STALL_EX], stall[STALL_MEM]);

  // Partial product survives only across the bubble EX requested.
  always_ff @(posedge Clk) begin
    if (Rst_n == RstEnable) begin
      hilo_o <= ZeroDouble;
      cnt_o  <= ZeroCnt;
    end else begin
      unique case (op)
        PR_BUBBLE: begin
          hilo_o <= hilo_i;
          cnt_o  <= cnt_i;
        end
        PR_ADVANCE: begin
          hilo_o <= ZeroDouble;
          cnt_o  <= ZeroCnt;
        end
        PR_HOLD: begin
          hilo_o <= hilo_o;
          cnt_o  <= cnt_o;
        end
        default: begin
          hilo_o <= hilo_o;
          cnt_o  <= cnt_o;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem.sv
// Randomized self-checking bench for ex_mem
// against a behavioural pipeline-register model.
module tb_ex_mem;

  logic        Clk;
  logic        Rst_n;
  logic [5:0]  stall;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic        ex_whilo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int n_chk;
  int n_fail;

  // model state
  logic [4:0]  e_wd;
  logic        e_wreg;
  logic [31:0] e_wdata;
  logic [31:0] e_hi;
  logic [31:0] e_lo;
  logic        e_whilo;
  logic [63:0] e_hilo;
  logic [1:0]  e_cnt;

  ex_mem dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .stall    (stall),
    .ex_wd    (ex_wd),
    .ex_wreg  (ex_wreg),
    .ex_wdata (ex_wdata),
    .ex_hi    (ex_hi),
    .ex_lo    (ex_lo),
    .ex_whilo (ex_whilo),
    .hilo_i   (hilo_i),
    .cnt_i    (cnt_i),
    .mem_wd   (mem_wd),
    .mem_wreg (mem_wreg),
    .mem_wdata(mem_wdata),
    .mem_hi   (mem_hi),
    .mem_lo   (mem_lo),
    .mem_whilo(mem_whilo),
    .hilo_o   (hilo_o),
    .cnt_o    (cnt_o)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("mem_wd",    64'(mem_wd),    64'(e_wd));
    check("mem_wreg",  64'(mem_wreg),  64'(e_wreg));
    check("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    check("mem_hi",    64'(mem_hi),    64'(e_hi));
    check("mem_lo",    64'(mem_lo),    64'(e_lo));
    check("mem_whilo", 64'(mem_whilo), 64'(e_whilo));
    check("hilo_o",    hilo_o,         e_hilo);
    check("cnt_o",     64'(cnt_o),     64'(e_cnt));
  endtask

  task automatic clear_mem();
    e_wd = '0; e_wreg = 0; e_wdata = '0;
    e_hi = '0; e_lo = '0; e_whilo = 0;
  endtask

  // One clock: apply the priority rules to the sampled inputs.
  task automatic step();
    bit ex_st, mem_st;
    @(posedge Clk);
    ex_st  = stall[3];
    mem_st = stall[4];
    if (Rst_n) begin
      clear_mem();
      e_hilo = '0;
      e_cnt  = '0;
    end else if (ex_st && !mem_st) begin
      clear_mem();
      e_hilo = hilo_i;
      e_cnt  = cnt_i;
    end else if (!ex_st) begin
      e_wd = ex_wd; e_wreg = ex_wreg; e_wdata = ex_wdata;
      e_hi = ex_hi; e_lo = ex_lo; e_whilo = ex_whilo;
      e_hilo = '0;
      e_cnt  = '0;
    end
    #1;
    check_all();
  endtask

  task automatic rand_ex();
    ex_wd    = 5'($urandom);
    ex_wreg  = 1'($urandom);
    ex_wdata = $urandom;
    ex_hi    = $urandom;
    ex_lo    = $urandom;
    ex_whilo = 1'($urandom);
    hilo_i   = {$urandom, $urandom};
    cnt_i    = 2'($urandom);
  endtask

  logic [5:0] stall_tab [4];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    stall_tab[0] = 6'b000000;
    stall_tab[1] = 6'b001111;
    stall_tab[2] = 6'b011111;
    stall_tab[3] = 6'b111111;

    Rst_n = 1;
    stall = '0;
    rand_ex();
    #1;
    step();
    check("rst_wd", 64'(mem_wd), 64'd0);

    // Advance
    Rst_n    = 0;
    stall    = 6'b000000;
    ex_wd    = 5'd8;
    ex_wreg  = 1;
    ex_wdata = 32'h1234_5678;
    step();
    check("adv_wdata", 64'(mem_wdata), 64'h1234_5678);
    check("adv_hilo",  hilo_o,         64'd0);

    // Hold with changing inputs
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      rand_ex();
      step();
      check("hold_wdata", 64'(mem_wdata), 64'h1234_5678);
      check("hold_wd",    64'(mem_wd),    64'd8);
    end

    // Reset with non-zero state
    Rst_n = 1;
    step();
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    Rst_n = 0;

    // Bubble
    stall   = 6'b001111;
    ex_wreg = 1;
    hilo_i  = 64'h0000_0001_FFFF_FFFE;
    cnt_i   = 2'd1;
    step();
    check("bub_wreg",  64'(mem_wreg),  64'd0);
    check("bub_wdata", 64'(mem_wdata), 64'd0);
    check("bub_hilo",  hilo_o,         64'h0000_0001_FFFF_FFFE);
    check("bub_cnt",   64'(cnt_o),     64'd1);

    // MADD step 2
    stall    = 6'b000000;
    ex_whilo = 1;
    ex_hi    = 32'h1;
    ex_lo    = 32'h2;
    cnt_i    = 2'd2;
    step();
    check("madd_whilo", 64'(mem_whilo), 64'd1);
    check("madd_hi",    64'(mem_hi),    64'd1);
    check("madd_lo",    64'(mem_lo),    64'd2);
    check("madd_cnt",   64'(cnt_o),     64'd0);

    // Reset mid-MADD
    stall  = 6'b001111;
    cnt_i  = 2'd1;
    hilo_i = 64'hDEAD_BEEF_0BAD_F00D;
    step();
    check("mid_cnt", 64'(cnt_o), 64'd1);
    Rst_n = 1;
    step();
    check("mid_rst_cnt",  64'(cnt_o), 64'd0);
    check("mid_rst_hilo", hilo_o,     64'd0);
    Rst_n = 0;

    for (int i = 0; i < 500; i++) begin
      rand_ex();
      stall = stall_tab[$urandom_range(3)];
      Rst_n = ($urandom_range(24) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
